// File: rtl/mode_sequencer.sv
// Mode/operation sequencer for the ALU demo datapath.
// Turns debounced button levels into mode steps, takes the operation from the
// switches, and can optionally run an auto-demo that walks every mode/operation
// pair on a slow tick. After every selection change it waits for the
// combinational datapath to settle, then pulses `capture` for one cycle so the
// display registers latch a stable result.
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   button0      debounced level, step mode up on rising edge
//   button1      debounced level, step mode down on rising edge
//   auto_en      level, requests auto-demo
//   tick         single-cycle enable from the slow divider
//   op_switches  manual operation select
//   mode         registered mode (0 arith, 1 logic, 2 compare, 3 magic)
//   operation    registered operation select
//   capture      one-cycle strobe: datapath result is stable
//   busy         high while settling
//   auto_active  high in AUTO, or while settling on the way back to AUTO
module mode_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DWELL_TICKS   = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       button0,
  input  logic       button1,
  input  logic       auto_en,
  input  logic       tick,
  input  logic [1:0] op_switches,
  output logic [1:0] mode,
  output logic [1:0] operation,
  output logic       capture,
  output logic       busy,
  output logic       auto_active
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_TICKS - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic [CW-1:0] dwell_cnt;
  logic          ret_auto;
  logic          b0_q;
  logic          b1_q;

  logic          rise0;
  logic          rise1;
  logic          step_up;
  logic          step_dn;
  logic [1:0]    manual_mode;
  logic          manual_change;
  logic          auto_step;
  logic [1:0]    auto_op;
  logic [1:0]    auto_mode;

  // Button edges; pressing both at once cancels out.
  assign rise0   = button0 & ~b0_q;
  assign rise1   = button1 & ~b1_q;
  assign step_up = rise0 & ~rise1;
  assign step_dn = rise1 & ~rise0;

  // Selection requested by the manual controls this cycle.
  assign manual_mode   = step_up ? mode + 2'd1 :
                         step_dn ? mode - 2'd1 : mode;
  assign manual_change = step_up | step_dn | (op_switches != operation);

  // Auto-demo step: operation walks 0..3, carrying into mode.
  assign auto_step = tick && (dwell_cnt == DWELL_LAST);
  assign auto_op   = operation + 2'd1;
  assign auto_mode = (operation == 2'd3) ? mode + 2'd1 : mode;

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SETTLE;
      settle_cnt  <= '0;
      dwell_cnt   <= '0;
      ret_auto    <= 1'b0;
      b0_q        <= 1'b0;
      b1_q        <= 1'b0;
      mode        <= 2'd0;
      operation   <= 2'd0;
      capture     <= 1'b0;
      busy        <= 1'b1;
      auto_active <= 1'b0;
    end else begin
      b0_q    <= button0;
      b1_q    <= button1;
      capture <= 1'b0;
      case (state)
        MANUAL: begin
          if (manual_change) begin
            mode       <= manual_mode;
            operation  <= op_switches;
            settle_cnt <= '0;
            ret_auto   <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end else if (auto_en) begin
            dwell_cnt   <= '0;
            auto_active <= 1'b1;
            state       <= AUTO;
          end
        end
        AUTO: begin
          if (auto_step) begin
            operation  <= auto_op;
            mode       <= auto_mode;
            dwell_cnt  <= '0;
            settle_cnt <= '0;
            ret_auto   <= 1'b1;
            busy       <= 1'b1;
            state      <= SETTLE;
          end else begin
            if (tick) begin
              dwell_cnt <= dwell_cnt + CW'(1);
            end
            if (!auto_en) begin
              auto_active <= 1'b0;
              state       <= MANUAL;
            end
          end
        end
        SETTLE: begin
          // Manual-return settling still follows the controls and restarts the wait.
          if (!ret_auto && manual_change) begin
            mode       <= manual_mode;
            operation  <= op_switches;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            capture   <= 1'b1;
            busy      <= 1'b0;
            dwell_cnt <= '0;
            if (ret_auto && auto_en) begin
              auto_active <= 1'b1;
              state       <= AUTO;
            end else begin
              auto_active <= 1'b0;
              state       <= MANUAL;
            end
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        default: begin
          state <= MANUAL;
        end
      endcase
    end
  end

endmodule
